// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser and per-bit debouncer for the board
// slide switches, with change pulse and sticky change mask for CPU polling.
//
// Ports:
//   clk         core clock, rising edge
//   rst         synchronous active-high reset
//   sw_raw      asynchronous switch pins (WIDTH)
//   change_clr  one-cycle acknowledge, clears change_mask
//   sw_stable   debounced switch state (WIDTH)
//   sw_changed  one-cycle pulse when any sw_stable bit updates
//   change_mask sticky per-bit update flags since last change_clr (WIDTH)
module sw_debounce #(
    parameter int WIDTH         = 16,
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             change_clr,
    output logic [WIDTH-1:0] sw_stable,
    output logic             sw_changed,
    output logic [WIDTH-1:0] change_mask
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] upd;
    logic             changed_q, changed_d;
    logic [WIDTH-1:0] mask_q, mask_d;

    // Each bit counts consecutive mismatches; any matching cycle restarts it.
    always_comb begin
        stable_d = stable_q;
        upd      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == LAST) begin
                    stable_d[i] = sync2_q[i];
                    upd[i]      = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        changed_d = |upd;
        // A same-cycle update beats the acknowledge for that bit.
        mask_d = (change_clr ? '0 : mask_q) | upd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            changed_q <= 1'b0;
            mask_q    <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sw_raw;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            changed_q <= changed_d;
            mask_q    <= mask_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_stable   = stable_q;
    assign sw_changed  = changed_q;
    assign change_mask = mask_q;

endmodule
